// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access controller: FSM encodings, branch bits, helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package mem_access_unit_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // branch_in bit positions
    localparam int BR_EQ_BIT = 0;
    localparam int BR_NE_BIT = 1;

    // Raw branch decision before stall gating
    function automatic logic branch_taken(input logic [1:0] br, input logic zero);
        return (br[BR_EQ_BIT] & zero) | (br[BR_NE_BIT] & ~zero);
    endfunction

    // Byte address to word-aligned bus address
    function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
        return {byte_addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts BUSY cycles of one data-memory access and flags expiry when no ack arrived in time.
// Latency: expired is combinational; it is high during the TIMEOUT_CYCLES-th BUSY cycle without ack.
// Backpressure: none; the counter simply clears whenever busy drops or the access ends.
module mem_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic busy,
    input  logic ack,
    output logic expired
);
    import mem_access_unit_pkg::*;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    // The access ends at this edge if the count is about to reach TIMEOUT_CYCLES
    assign expired = busy & ~ack & (cnt == LAST);

    // Count BUSY cycles; clear on reset, outside BUSY and whenever the access ends
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!busy || ack || expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: issues a req/ack data-memory access, resolves branches, presents the WB result.
// Latency: an ack on the Nth BUSY cycle gives N+1 stall cycles, then one DONE cycle with mem_stall=0.
// Backpressure: mem_stall holds the upstream pipeline while an access is outstanding; MEM_TIMEOUT_EN adds a bus timeout.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc_in,
    input  logic [31:0] alu_c_in,
    input  logic [31:0] rt_data_in,
    input  logic        zero_in,
    input  logic [4:0]  reg_rd_in,
    input  logic [1:0]  branch_in,
    input  logic        memr_in,
    input  logic        memw_in,
    input  logic        regw_in,
    input  logic        mem2reg_in,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        mem_stall,
    output logic        pc_src,
    output logic [31:0] branch_tgt,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_regw,
    output logic        bus_err
);
    import mem_access_unit_pkg::*;

    logic [1:0]  state;
    logic [31:0] rdata_q;
    logic        mem_op;
    logic        is_load;
    logic        timeout_hit;

    assign mem_op  = memr_in | memw_in;
    // A simultaneous read+write is a store; no read data is captured
    assign is_load = memr_in & ~memw_in;

`ifdef MEM_TIMEOUT_EN
    mem_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .busy    (state == ST_BUSY),
        .ack     (dm_ack),
        .expired (timeout_hit)
    );

    // Sticky bus error, set on timeout and cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus_err <= 1'b0;
        end else if (timeout_hit) begin
            bus_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

    // Access FSM: issue from IDLE, wait for ack in BUSY, release the pipeline for one DONE cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            dm_req  <= 1'b0;
            dm_we   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_op) begin
                        state  <= ST_BUSY;
                        dm_req <= 1'b1;
                        dm_we  <= memw_in;
                    end
                end
                ST_BUSY: begin
                    if (dm_ack) begin
                        if (is_load) begin
                            rdata_q <= dm_rdata;
                        end
                        dm_req <= 1'b0;
                        state  <= ST_DONE;
                    end else if (timeout_hit) begin
                        dm_req  <= 1'b0;
                        rdata_q <= '0;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    dm_we <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    dm_req <= 1'b0;
                    dm_we  <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    // EX/MEM is frozen during an access, so address and data can be driven straight through
    assign dm_addr  = word_addr(alu_c_in);
    assign dm_wdata = rt_data_in;

    // Stall from the request cycle in IDLE through every BUSY cycle
    assign mem_stall = ((state == ST_IDLE) & mem_op) | (state == ST_BUSY);

    // Branch and writeback outputs; gating by mem_stall makes each commit happen once
    assign pc_src     = branch_taken(branch_in, zero_in) & ~mem_stall;
    assign branch_tgt = npc_in;
    assign wb_data    = mem2reg_in ? rdata_q : alu_c_in;
    assign wb_rd      = reg_rd_in;
    assign wb_regw    = regw_in & ~mem_stall;

endmodule
